maj_bist_ctrl: RTL
==================

MAJ_BIST_CTRL -- requirements
Module: maj_bist_ctrl

Interface
REQ-001 SHALL have parameter N, default 61, meaning majority DUT input width (odd, 3..63).
REQ-002 SHALL have parameter NUM_RANDOM, default 1024, meaning pseudo-random vectors per run (1..65535).
REQ-003 SHALL have parameter DUT_LAT, default 0, meaning DUT pipeline cycles between x_out and y_in (0..7).
REQ-004 SHALL have parameter SEED, default 64'hACE1_0000_0000_0001, meaning LFSR load value (nonzero).
REQ-005 SHALL have port clk, in, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, in, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, in, 1, run request.
REQ-008 SHALL have port x_out, out, N, registered vector driven to DUT inputs x0..x(N-1).
REQ-009 SHALL have port y_in, in, 1, DUT output y0.
REQ-010 SHALL have port busy, out, 1, run in progress.
REQ-011 SHALL have port done, out, 1, run complete (level, held until next accepted start).
REQ-012 SHALL have port pass, out, 1, done with zero mismatches.
REQ-013 SHALL have port err_count, out, 16, mismatch count, saturating at 16'hFFFF.
REQ-014 SHALL have ports fail_valid, out, 1, and fail_vec, out, N, first mismatching vector captured.

Function
REQ-015 SHALL implement FSM states IDLE, DIR, RND, DRAIN, DONE.
REQ-016 IDLE/DONE: start high at edge e0 -> DIR; clear err_count, fail_valid, fail_vec, done, pass; reload LFSR with SEED; x_out = vector 0 at e0.
REQ-017 start while busy SHALL be ignored; start held high in DONE SHALL restart.
REQ-018 DIR: vector k (k=0..N) = k least-significant ones (thermometer); one vector per cycle; after k=N -> RND.
REQ-019 RND: vector = LFSR[N-1:0]; LFSR advances once per vector; 64-bit Galois, polynomial x^64+x^63+x^61+x^60+1; after NUM_RANDOM vectors -> DRAIN.
REQ-020 Expected = (popcount(x_out) >= (N+1)/2); expected and x_out SHALL be delayed DUT_LAT+1 cycles.
REQ-021 Vector issued at edge c SHALL be compared with y_in sampled at edge c+1+DUT_LAT.
REQ-022 Mismatch: err_count increments (saturating); first mismatch sets fail_valid=1 and latches the aligned vector into fail_vec; later mismatches do not overwrite.
REQ-023 DRAIN lasts until the last vector is compared, then DONE; done rises at edge e0+N+1+NUM_RANDOM+DUT_LAT+1 (1087 cycles with defaults).
REQ-024 busy = 1 in DIR, RND, DRAIN only; x_out = 0 in IDLE, DRAIN, DONE.
REQ-025 pass = done AND err_count==0; pass = 0 whenever done = 0.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE and zero x_out, busy, done, pass, err_count, fail_valid, fail_vec, delay lines; LFSR = SEED.
REQ-027 Reset mid-run SHALL abort with no done pulse; next run requires a new start.

Structure
REQ-028 Package maj_bist_pkg SHALL hold the state enum, LFSR width and tap constant, and the default SEED.
REQ-029 Sub-module maj_ref_threshold (N-bit popcount, >= (N+1)/2 compare, combinational) SHALL compute expected.
REQ-030 Total RTL SHALL be 120-400 lines.

Verification
REQ-031 Ideal Maj61 model, defaults: start pulse -> done at +1087 cycles, pass=1, err_count=0, fail_valid=0.
REQ-032 y_in stuck-at-0: err_count >= 31, fail_valid=1, fail_vec = 31 low ones (first mismatch at k=31).
REQ-033 Threshold-off-by-one model (popcount>=30), fault-free otherwise: fail_vec = 30 low ones, pass=0.
REQ-034 DUT_LAT=2 with 2-stage pipelined ideal model: pass=1, done at +1089 cycles.
REQ-035 start re-pulsed during RND -> no effect; rst_n low at cycle 500 -> all outputs 0 immediately, stays IDLE.
REQ-036 Forced 20 mismatches then err_count=16'hFFFF preload in a saturation run: count holds at 16'hFFFF.

Source files
------------

// File: rtl/maj_bist_pkg.sv
// Shared types and constants for the majority-gate BIST controller.
// The LFSR is a 64-bit right-shifting Galois generator for x^64+x^63+x^61+x^60+1.
package maj_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DIR,
    RND,
    DRAIN,
    DONE
  } state_e;

  localparam int          LFSR_W       = 64;
  localparam logic [63:0] LFSR_TAPS    = 64'hD800_0000_0000_0000;
  localparam logic [63:0] DEFAULT_SEED = 64'hACE1_0000_0000_0001;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ LFSR_TAPS;
    return r;
  endfunction

endpackage

// File: rtl/maj_ref_threshold.sv
// Golden majority reference: popcount of the vector compared against (N+1)/2.
// Purely combinational; the controller feeds it the latency-aligned vector.
module maj_ref_threshold #(
  parameter int N = 61
) (
  input  logic [N-1:0] vec,
  output logic         maj
);

  localparam int            CW     = $clog2(N + 1);
  localparam logic [CW-1:0] THRESH = CW'((N + 1) / 2);

  logic [CW-1:0] ones;

  always_comb begin
    ones = '0;
    for (int i = 0; i < N; i++) ones = ones + CW'(vec[i]);
  end

  assign maj = (ones >= THRESH);

endmodule

// File: rtl/maj_bist_ctrl.sv
// BIST controller for an N-input majority gate: thermometer sweep, then LFSR vectors,
// each compared against the reference after DUT_LAT+1 cycles of alignment.
module maj_bist_ctrl
  import maj_bist_pkg::*;
#(
  parameter int                N          = 61,
  parameter int                NUM_RANDOM = 1024,
  parameter int                DUT_LAT    = 0,
  parameter logic [LFSR_W-1:0] SEED       = DEFAULT_SEED
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [N-1:0] x_out,
  input  logic         y_in,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [15:0]  err_count,
  output logic         fail_valid,
  output logic [N-1:0] fail_vec
);

  state_e              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [15:0]         err_q, err_d;
  logic                fail_valid_q, fail_valid_d;
  logic [N-1:0]        fail_vec_q, fail_vec_d;
  logic [N-1:0]        x_out_d;
  logic                vld_d;

  // Stage 0 is the x_out register itself; the tap at DUT_LAT lines up with y_in.
  logic [N-1:0]        vec_pipe_q [DUT_LAT+1];
  logic [DUT_LAT:0]    vld_pipe_q;

  logic [N-1:0]        aligned_vec;
  logic                aligned_vld;
  logic                exp_maj;
  logic                mismatch;

  assign aligned_vec = vec_pipe_q[DUT_LAT];
  assign aligned_vld = vld_pipe_q[DUT_LAT];

  maj_ref_threshold #(.N(N)) u_ref (
    .vec (aligned_vec),
    .maj (exp_maj)
  );

  assign mismatch = aligned_vld && (y_in != exp_maj);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lfsr_d       = lfsr_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    x_out_d      = '0;
    vld_d        = 1'b0;

    if (mismatch) begin
      if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      if (!fail_valid_q) begin
        fail_valid_d = 1'b1;
        fail_vec_d   = aligned_vec;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = DIR;
          cnt_d        = 16'd1;
          lfsr_d       = SEED;
          vld_d        = 1'b1;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
        end
      end
      DIR: begin
        for (int i = 0; i < N; i++) x_out_d[i] = (16'(i) < cnt_q);
        vld_d = 1'b1;
        if (cnt_q == 16'(N)) begin
          state_d = RND;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RND: begin
        x_out_d = lfsr_q[N-1:0];
        vld_d   = 1'b1;
        lfsr_d  = lfsr_next(lfsr_q);
        if (cnt_q == 16'(NUM_RANDOM - 1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DRAIN: begin
        // One extra cycle past the last comparison so err_count is final when done rises.
        if (cnt_q == 16'(DUT_LAT + 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 16'd0);
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lfsr_q       <= SEED;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lfsr_q       <= lfsr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= DUT_LAT; i++) vec_pipe_q[i] <= '0;
      vld_pipe_q <= '0;
    end else begin
      vec_pipe_q[0] <= x_out_d;
      vld_pipe_q[0] <= vld_d;
      for (int i = 1; i <= DUT_LAT; i++) begin
        vec_pipe_q[i] <= vec_pipe_q[i-1];
        vld_pipe_q[i] <= vld_pipe_q[i-1];
      end
    end
  end

  assign x_out      = vec_pipe_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule
